// File: rtl/ram_ws.sv
// Dual-port byte-addressable little-endian RAM with wait states, byte-enable writes,
// range checking and a debug read port. Each port runs its own accept/wait/done sequencer.

module ram_ws_fsm #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic stall,
    output logic accept,
    output logic done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    assign accept = (state == S_IDLE) && req && !stall;
    assign done   = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) state <= S_DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

module ram_ws #(
    parameter int MEM_SIZE    = 'h2024,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req1,
    input  logic [ADDR_W-1:0]      addr1,
    output logic                   ready1,
    output logic [DATA_W-1:0]      rd1,
    output logic                   err1,
    input  logic                   req2,
    input  logic                   we2,
    input  logic [DATA_W/8-1:0]    be2,
    input  logic [ADDR_W-1:0]      addr2,
    input  logic [DATA_W-1:0]      wd2,
    output logic                   ready2,
    output logic [DATA_W-1:0]      rd2,
    output logic                   err2,
    input  logic                   dbg_en,
    input  logic [ADDR_W-1:0]      dbg_addr,
    output logic [DATA_W-1:0]      dbg_rd
);
    localparam int BYTES = DATA_W / 8;
    localparam int AW1   = ADDR_W + 1;
    localparam int IDX_W = $clog2(MEM_SIZE);
    // Highest word base that still fits entirely inside the array.
    localparam logic [ADDR_W:0] LIMIT = AW1'(MEM_SIZE - BYTES);

    typedef struct packed {
        logic              we;
        logic [BYTES-1:0]  be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
    } p2_req_t;

    logic [7:0]        mem [MEM_SIZE];
    logic [ADDR_W-1:0] q1;
    p2_req_t           q2;
    logic [1:0]        p_req, p_stall, p_acc, p_done;

    assign p_req   = {req2, req1};
    assign p_stall = {1'b0, dbg_en};

    for (genvar p = 0; p < 2; p++) begin : g_port
        ram_ws_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_fsm (
            .clk    (clk),
            .rst    (rst),
            .req    (p_req[p]),
            .stall  (p_stall[p]),
            .accept (p_acc[p]),
            .done   (p_done[p])
        );
    end

    function automatic logic [ADDR_W:0] word_of(input logic [ADDR_W-1:0] a);
        return {1'b0, a & ~ADDR_W'(BYTES - 1)};
    endfunction

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return word_of(a) > LIMIT;
    endfunction

    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        logic [IDX_W-1:0]  base;
        w    = '0;
        base = IDX_W'(word_of(a));
        if (!out_of_range(a))
            for (int i = 0; i < BYTES; i++) w[8*i +: 8] = mem[base + IDX_W'(i)];
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= '0;
            q2 <= '0;
        end else begin
            if (p_acc[0]) q1 <= addr1;
            if (p_acc[1]) q2 <= {we2, be2, addr2, wd2};
        end
    end

    // Reads sample mem before this edge's write lands, giving read-before-write on collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready1 <= 1'b0;
            rd1    <= '0;
            err1   <= 1'b0;
            ready2 <= 1'b0;
            rd2    <= '0;
            err2   <= 1'b0;
            dbg_rd <= '0;
        end else begin
            ready1 <= p_done[0];
            err1   <= p_done[0] && out_of_range(q1);
            rd1    <= (p_done[0] && !out_of_range(q1)) ? rd_word(q1) : '0;
            ready2 <= p_done[1];
            err2   <= p_done[1] && out_of_range(q2.addr);
            rd2    <= (p_done[1] && !q2.we && !out_of_range(q2.addr)) ? rd_word(q2.addr) : '0;
            if (dbg_en) dbg_rd <= rd_word(dbg_addr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && p_done[1] && q2.we && !out_of_range(q2.addr)) begin
            for (int i = 0; i < BYTES; i++)
                if (q2.be[i]) mem[IDX_W'(word_of(q2.addr)) + IDX_W'(i)] <= q2.wd[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_ram_ws.sv
// Bench for ram_ws: three instances (WAIT_CYCLES 1, 0, 3) checked against a byte-array model,
// with a vector table, hand-written corner sequences and randomized traffic.

module tb_ram_ws;
    localparam int MEM = 'h2024;
    localparam int NI  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req1 [NI];
    logic [31:0] addr1 [NI];
    logic        ready1 [NI];
    logic [31:0] rd1 [NI];
    logic        err1 [NI];
    logic        req2 [NI];
    logic        we2 [NI];
    logic [3:0]  be2 [NI];
    logic [31:0] addr2 [NI];
    logic [31:0] wd2 [NI];
    logic        ready2 [NI];
    logic [31:0] rd2 [NI];
    logic        err2 [NI];
    logic        dbg_en [NI];
    logic [31:0] dbg_addr [NI];
    logic [31:0] dbg_rd [NI];

    logic [7:0] model [NI][MEM];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        ram_ws #(
            .MEM_SIZE(MEM), .DATA_W(32), .ADDR_W(32),
            .WAIT_CYCLES((k == 0) ? 1 : (k == 1) ? 0 : 3)
        ) u_dut (
            .clk(clk), .rst(rst),
            .req1(req1[k]), .addr1(addr1[k]), .ready1(ready1[k]), .rd1(rd1[k]), .err1(err1[k]),
            .req2(req2[k]), .we2(we2[k]), .be2(be2[k]), .addr2(addr2[k]), .wd2(wd2[k]),
            .ready2(ready2[k]), .rd2(rd2[k]), .err2(err2[k]),
            .dbg_en(dbg_en[k]), .dbg_addr(dbg_addr[k]), .dbg_rd(dbg_rd[k])
        );
    end

    function automatic int wc(int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic poke(input int k, input int a, input logic [7:0] v);
        case (k)
            0:       g_dut[0].u_dut.mem[a] <= v;
            1:       g_dut[1].u_dut.mem[a] <= v;
            default: g_dut[2].u_dut.mem[a] <= v;
        endcase
        model[k][a] = v;
    endtask

    function automatic logic [7:0] peek(int k, int a);
        case (k)
            0:       return g_dut[0].u_dut.mem[a];
            1:       return g_dut[1].u_dut.mem[a];
            default: return g_dut[2].u_dut.mem[a];
        endcase
    endfunction

    // Reference model: plain byte array, word = address rounded down to 4.
    function automatic bit m_oor(logic [31:0] a);
        longint w;
        w = longint'(a & 32'hFFFF_FFFC);
        return (w + 4) > MEM;
    endfunction

    function automatic logic [31:0] m_rd(int k, logic [31:0] a);
        logic [31:0] v;
        int w;
        v = '0;
        if (m_oor(a)) return v;
        w = int'(a & 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) v[8*i +: 8] = model[k][w + i];
        return v;
    endfunction

    task automatic m_wr(input int k, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        int w;
        if (m_oor(a)) return;
        w = int'(a & 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) if (be[i]) model[k][w + i] = wd[8*i +: 8];
    endtask

    // Called at a negedge; returns at the negedge where ready is seen. lat = cycles after accept.
    task automatic p1_txn(input int k, input logic [31:0] a,
                          output logic [31:0] rd, output logic er, output int lat);
        bit seen = 0;
        addr1[k] = a; req1[k] = 1'b1;
        rd = '0; er = 1'b0; lat = -1;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (ready1[k]) begin seen = 1; lat = n - 1; rd = rd1[k]; er = err1[k]; end
        end
        req1[k] = 1'b0;
        if (!seen) chk($sformatf("p1_timeout_k%0d", k), 1, 0);
    endtask

    task automatic p2_txn(input int k, input logic we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        bit seen = 0;
        we2[k] = we; be2[k] = be; addr2[k] = a; wd2[k] = wd; req2[k] = 1'b1;
        rd = '0; er = 1'b0; lat = -1;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (ready2[k]) begin seen = 1; lat = n - 1; rd = rd2[k]; er = err2[k]; end
        end
        req2[k] = 1'b0;
        we2[k] = $urandom_range(0, 1);
        wd2[k] = $urandom;
        if (!seen) chk($sformatf("p2_timeout_k%0d", k), 1, 0);
    endtask

    task automatic sc_read8(input int k);
        logic [31:0] rd; logic er; int lat;
        poke(k, 8, 8'h78); poke(k, 9, 8'h56); poke(k, 10, 8'h34); poke(k, 11, 8'h12);
        @(negedge clk);
        p1_txn(k, 32'd8, rd, er, lat);
        chk($sformatf("read8_rd_k%0d", k), rd, 32'h1234_5678);
        chk($sformatf("read8_err_k%0d", k), er, 0);
        chk($sformatf("read8_lat_k%0d", k), lat, wc(k) + 1);
        @(negedge clk);
        chk($sformatf("read8_pulse_k%0d", k), ready1[k], 0);
    endtask

    task automatic sc_collide(input int k);
        logic [31:0] r1, r2; logic e1, e2; int l1, l2;
        fork
            p1_txn(k, 32'd8, r1, e1, l1);
            p2_txn(k, 1'b1, 4'hF, 32'd8, 32'hCAFE_F00D, r2, e2, l2);
        join
        m_wr(k, 32'd8, 4'hF, 32'hCAFE_F00D);
        chk($sformatf("coll_rd1_k%0d", k), r1, 32'h1234_5678);
        chk($sformatf("coll_same_cycle_k%0d", k), l1, l2);
        chk($sformatf("coll_err2_k%0d", k), e2, 0);
        p1_txn(k, 32'd8, r1, e1, l1);
        chk($sformatf("coll_after_k%0d", k), r1, 32'hCAFE_F00D);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic rnd_run(input int k, input int n);
        logic [31:0] a1, a2, wd, e1, e2, r1, r2;
        logic [3:0]  be;
        logic        we, o1, o2, x1, x2;
        int mode, l1, l2;
        for (int it = 0; it < n; it++) begin
            mode = $urandom_range(0, 2);
            a1 = rnd_addr(); a2 = rnd_addr();
            we = $urandom_range(0, 1); be = 4'($urandom_range(0, 15)); wd = $urandom;
            e1 = m_rd(k, a1); o1 = m_oor(a1);
            e2 = m_rd(k, a2); o2 = m_oor(a2);
            if (mode == 0) p1_txn(k, a1, r1, x1, l1);
            else if (mode == 1) p2_txn(k, we, be, a2, wd, r2, x2, l2);
            else fork
                p1_txn(k, a1, r1, x1, l1);
                p2_txn(k, we, be, a2, wd, r2, x2, l2);
            join
            if (mode != 1) begin
                chk($sformatf("rnd_rd1_k%0d_%0d", k, it), r1, e1);
                chk($sformatf("rnd_err1_k%0d_%0d", k, it), x1, o1);
            end
            if (mode != 0) begin
                chk($sformatf("rnd_err2_k%0d_%0d", k, it), x2, o2);
                chk($sformatf("rnd_lat2_k%0d_%0d", k, it), l2, wc(k) + 1);
                if (!we) chk($sformatf("rnd_rd2_k%0d_%0d", k, it), r2, e2);
                else     m_wr(k, a2, be, wd);
            end
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'(MEM - 8) + 32'($urandom_range(0, 11));
        if (r == 1) return $urandom;
        return 32'($urandom_range(0, 47));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [10];
        logic [31:0] rd, w16; logic er; int lat, seen, bad;

        // The last word (0x2020..0x2023) fits exactly, so addr MEM_SIZE-2 is in range.
        tbl[0] = '{1'b1, 4'b0101, 32'd12,         32'hAABB_CCDD, 32'h0,          1'b0};
        tbl[1] = '{1'b0, 4'hF,    32'd12,         32'h0,         32'h00BB_00DD,  1'b0};
        tbl[2] = '{1'b0, 4'hF,    32'd13,         32'h0,         32'h00BB_00DD,  1'b0};
        tbl[3] = '{1'b1, 4'hF,    32'(MEM - 2),   32'h1122_3344, 32'h0,          1'b0};
        tbl[4] = '{1'b0, 4'hF,    32'h2020,       32'h0,         32'h1122_3344,  1'b0};
        tbl[5] = '{1'b0, 4'hF,    32'h2023,       32'h0,         32'h1122_3344,  1'b0};
        tbl[6] = '{1'b1, 4'hF,    32'(MEM),       32'hFFFF_FFFF, 32'h0,          1'b1};
        tbl[7] = '{1'b1, 4'hF,    32'hFFFF_0000,  32'h5555_AAAA, 32'h0,          1'b1};
        tbl[8] = '{1'b0, 4'hF,    32'hFFFF_0000,  32'h0,         32'h0,          1'b1};
        tbl[9] = '{1'b0, 4'hF,    32'h2024,       32'h0,         32'h0,          1'b1};

        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            req1[k] = 0; addr1[k] = 0; req2[k] = 0; we2[k] = 0; be2[k] = 0;
            addr2[k] = 0; wd2[k] = 0; dbg_en[k] = 0; dbg_addr[k] = 0;
            for (int a = 0; a < MEM; a++) poke(k, a, 8'h00);
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset_ctl_k%0d", k), {ready1[k], ready2[k], err1[k], err2[k]}, 0);
            chk($sformatf("reset_rd_k%0d", k), {rd1[k], rd2[k]}, 0);
            chk($sformatf("reset_dbg_k%0d", k), dbg_rd[k], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        sc_read8(0);

        for (int i = 0; i < 10; i++) begin
            p2_txn(0, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wd, rd, er, lat);
            if (tbl[i].we) m_wr(0, tbl[i].addr, tbl[i].be, tbl[i].wd);
            else chk($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_err", i), er, tbl[i].exp_err);
            chk($sformatf("vec%0d_lat", i), lat, 2);
        end

        sc_collide(0);

        // Debug read holds off a pending port 1 request.
        dbg_addr[0] = 32'd12; dbg_en[0] = 1'b1; addr1[0] = 32'd12; req1[0] = 1'b1;
        seen = 0;
        repeat (6) begin @(negedge clk); if (ready1[0]) seen++; end
        chk("dbg_stall", seen, 0);
        chk("dbg_rd", dbg_rd[0], 32'h00BB_00DD);
        dbg_en[0] = 1'b0; dbg_addr[0] = 32'd8;
        lat = -1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (ready1[0]) begin lat = n; rd = rd1[0]; end
        end
        req1[0] = 1'b0;
        chk("dbg_release_lat", lat, wc(0) + 2);
        chk("dbg_release_rd1", rd, 32'h00BB_00DD);
        chk("dbg_hold", dbg_rd[0], 32'h00BB_00DD);
        dbg_addr[0] = 32'hFFFF_0000; dbg_en[0] = 1'b1;
        @(negedge clk);
        dbg_en[0] = 1'b0;
        chk("dbg_oor", dbg_rd[0], 0);

        // Held request re-launches right after the completion cycle.
        addr1[0] = 32'd8; req1[0] = 1'b1;
        lat = -1; seen = -1;
        for (int n = 1; n <= 40 && seen < 0; n++) begin
            @(negedge clk);
            if (ready1[0]) begin
                if (lat < 0) lat = n;
                else begin seen = n - lat; rd = rd1[0]; end
            end
        end
        req1[0] = 1'b0;
        chk("hold_period", seen, wc(0) + 2);
        chk("hold_rd1", rd, 32'hCAFE_F00D);
        @(negedge clk);

        // Reset while a write waits: write is dropped, port usable right after.
        we2[0] = 1'b1; be2[0] = 4'hF; addr2[0] = 32'd16; wd2[0] = 32'hDEAD_BEEF; req2[0] = 1'b1;
        @(negedge clk);
        rst = 1'b1; req2[0] = 1'b0;
        @(negedge clk);
        chk("rst_ready2", ready2[0], 0);
        rst = 1'b0;
        w16 = {peek(0, 19), peek(0, 18), peek(0, 17), peek(0, 16)};
        chk("rst_mem", w16, m_rd(0, 32'd16));
        p2_txn(0, 1'b0, 4'hF, 32'd16, 32'h0, rd, er, lat);
        chk("rst_reaccept_lat", lat, wc(0) + 1);
        chk("rst_read16", rd, m_rd(0, 32'd16));

        for (int k = 1; k < NI; k++) begin
            sc_read8(k);
            sc_collide(k);
        end

        for (int k = 0; k < NI; k++) rnd_run(k, 120);

        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            bad = 0;
            for (int a = 0; a < MEM; a++) if (peek(k, a) !== model[k][a]) bad++;
            chk($sformatf("mem_final_k%0d", k), bad, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
